// File: rtl/sb_pkg.sv
// Shared sideband types: widths, opcode enum, queued message record and FSM states.
package sb_pkg;

    localparam int SB_PHASE_W         = 64;
    localparam int SB_HDR_W           = 62;
    localparam int SB_MAX_DATA_PHASES = 4;
    localparam int SB_MAX_DATA_W      = SB_MAX_DATA_PHASES * SB_PHASE_W;
    localparam int SB_OPC_W           = 4;

    typedef enum logic [SB_OPC_W-1:0] {
        SB_OPC_NOP        = 4'd0,
        SB_OPC_MEM_RD     = 4'd1,
        SB_OPC_MEM_WR     = 4'd2,
        SB_OPC_CFG_RD     = 4'd3,
        SB_OPC_CFG_WR     = 4'd4,
        SB_OPC_TIMEOUT    = 4'd5,
        SB_OPC_COMPLETION = 4'd6,
        SB_OPC_MSG        = 4'd7
    } sb_opc_t;

    // One queued message. Data is sized for the largest supported payload;
    // the framer only ever reads the slices it was configured for.
    typedef struct packed {
        logic [SB_HDR_W-1:0]      header;
        logic [SB_MAX_DATA_W-1:0] data;
        logic                     has_data;
        logic                     cp;
        logic                     dp;
    } sb_msg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } sb_state_t;

    // Header phase layout: {data parity, control parity, header}.
    function automatic logic [SB_PHASE_W-1:0] sb_hdr_phase(input sb_msg_t m);
        return {m.dp, m.cp, m.header};
    endfunction

endpackage

// File: rtl/sb_msg_fifo.sv
// Show-ahead message queue. Head and the entry behind it are readable
// combinationally so the framer can start the next header without a bubble.
import sb_pkg::*;

module sb_msg_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  sb_msg_t                    push_msg,
    input  logic                       pop,
    output sb_msg_t                    head_msg,
    output sb_msg_t                    next_msg,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    sb_msg_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Full blocks pushes even when a pop happens in the same cycle.
    assign full        = (count_reg == CNT_W'(DEPTH));
    assign empty       = (count_reg == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(1);

    assign head_msg = mem[rd_ptr_reg];
    assign next_msg = mem[rd_ptr_next];
    assign count    = count_reg;

    // Entry storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_msg;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sb_packet_framer_q.sv
// Sideband framer: queues whole messages and emits them as header and
// data phases over a valid/ready link to the serializer.
import sb_pkg::*;

module sb_packet_framer_q #(
    parameter int HDR_W       = SB_HDR_W,
    parameter int PHASE_W     = SB_PHASE_W,
    parameter int DATA_PHASES = 1,
    parameter int DEPTH       = 4,
    parameter int OPC_LSB     = 14,
    parameter int OPC_W       = 4,
    parameter int TIMEOUT_OPC = int'(SB_OPC_TIMEOUT)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_msg_valid,
    output logic                           o_msg_ready,
    input  logic [HDR_W-1:0]               i_header,
    input  logic [DATA_PHASES*PHASE_W-1:0] i_data,
    input  logic                           i_has_data,
    output logic [PHASE_W-1:0]             o_phase,
    output logic                           o_phase_valid,
    input  logic                           i_ser_ready,
    output logic                           o_timeout_ctr_start,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int               DATA_W = DATA_PHASES * PHASE_W;
    localparam int               CNT_W  = $clog2(DEPTH+1);
    localparam logic [1:0]       K_LAST = 2'(DATA_PHASES - 1);
    localparam logic [OPC_W-1:0] TO_OPC = OPC_W'(TIMEOUT_OPC);

    sb_msg_t          in_msg;
    sb_msg_t          head_msg;
    sb_msg_t          next_msg;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic             xfer;
    logic             more_msgs;

    sb_state_t        state_reg;
    logic [1:0]       k_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic             phase_valid_reg;
    logic             timeout_reg;

    logic [PHASE_W-1:0] head_slice [SB_MAX_DATA_PHASES];

    // Only the header and parities of the following entry are needed.
    logic unused_next_bits;
    assign unused_next_bits = ^{next_msg.data, next_msg.has_data};

    // Build the stored entry; parity is fixed here so send time never recomputes it.
    always_comb begin
        in_msg          = '0;
        in_msg.header   = i_header;
        in_msg.has_data = i_has_data;
        in_msg.cp       = ^i_header;
        if (i_has_data) begin
            in_msg.data[DATA_W-1:0] = i_data;
            in_msg.dp               = ^i_data;
        end
    end

    assign push = i_msg_valid && !fifo_full;

    sb_msg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .push_msg (in_msg),
        .pop      (pop),
        .head_msg (head_msg),
        .next_msg (next_msg),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Split the head payload into phase-sized slices, LSB slice first.
    for (genvar gi = 0; gi < SB_MAX_DATA_PHASES; gi++) begin : g_slice
        assign head_slice[gi] = head_msg.data[gi*PHASE_W +: PHASE_W];
    end

    assign xfer = phase_valid_reg && i_ser_ready;
    // A second entry already queued lets the next header follow immediately;
    // a same-cycle push is not yet counted, so it never qualifies.
    assign more_msgs = (fifo_count >= CNT_W'(2));
    assign pop = xfer && (((state_reg == ST_HDR) && !head_msg.has_data) ||
                          ((state_reg == ST_DATA) && (k_reg == K_LAST)));

    // Framer FSM with registered phase, valid and timeout-start outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= ST_IDLE;
            k_reg           <= '0;
            phase_reg       <= '0;
            phase_valid_reg <= 1'b0;
            timeout_reg     <= 1'b0;
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        phase_reg       <= sb_hdr_phase(head_msg);
                        phase_valid_reg <= 1'b1;
                        state_reg       <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (xfer) begin
                        timeout_reg <= (head_msg.header[OPC_LSB +: OPC_W] == TO_OPC);
                        if (head_msg.has_data) begin
                            k_reg     <= '0;
                            phase_reg <= head_slice[0];
                            state_reg <= ST_DATA;
                        end else if (more_msgs) begin
                            phase_reg <= sb_hdr_phase(next_msg);
                        end else begin
                            phase_valid_reg <= 1'b0;
                            state_reg       <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (k_reg != K_LAST) begin
                            k_reg     <= k_reg + 2'd1;
                            phase_reg <= head_slice[k_reg + 2'd1];
                        end else if (more_msgs) begin
                            phase_reg <= sb_hdr_phase(next_msg);
                            state_reg <= ST_HDR;
                        end else begin
                            phase_valid_reg <= 1'b0;
                            state_reg       <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    phase_valid_reg <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_msg_ready         = !fifo_full;
    assign o_phase             = phase_reg;
    assign o_phase_valid       = phase_valid_reg;
    assign o_timeout_ctr_start = timeout_reg;
    assign o_count             = fifo_count;

endmodule
